stream_demux1_4: RTL and testbench
==================================

Name: stream_demux1_4

Overview:
- Registered 1-to-4 stream demultiplexer with a valid/ready handshake on the input and on each output.
- Sits directly downstream of the team's bit-level demux primitives: it routes one input beat per cycle to one of four channel holding registers.
- Provides per-channel backpressure. A full or stalled channel blocks only beats addressed to that channel.
- Destination comes from an explicit select, or from an internal round-robin pointer when the optional feature is compiled in.

Parameters:
- DW, 8, data width of each beat in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream beat is valid.
- in_ready  output  1  block can accept the beat (combinational).
- in_data  input  DW  upstream beat data.
- in_sel  input  2  destination channel 0..3; ignored when DEMUX_RR_EN is defined.
- out_valid  output  4  bit k: channel k holds a valid beat.
- out_ready  input  4  bit k: downstream consumer k accepts the beat.
- out_data  output  4*DW  channel k occupies bits [k*DW +: DW].
- rr_ptr  output  2  current round-robin destination; constant 0 without DEMUX_RR_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=4'b0000, out_data all zero, rr_ptr=0.
  - in_ready follows its equation from these register values.
  - Reset asserted mid-transfer discards all held beats immediately. No partial beat survives.
- Destination: dst = in_sel, or rr_ptr when DEMUX_RR_EN is defined.
- Ready equation: in_ready = !out_valid[dst] | out_ready[dst].
  - This is a combinational path from out_ready to in_ready and is intentional.
  - in_ready depends only on channel dst. It does not depend on in_valid.
- Accept: when in_valid & in_ready at a rising edge:
  - out_data[dst] <= in_data and out_valid[dst] <= 1.
  - Latency is 1 cycle: data is visible on the cycle after acceptance.
- Drain: when out_valid[k] & out_ready[k] and channel k is not being reloaded that edge, out_valid[k] <= 0.
  - out_data[k] holds its last value; it is never cleared except by reset.
- Drain and reload in the same edge on the same channel: the new beat loads, out_valid[k] stays 1, no bubble.
  - This sustains 1 beat/cycle to a single channel whose consumer is always ready.
- Channels are independent. A drain on channel j does not affect channel k≠j. At most one channel loads per edge.
- Holding channel with out_ready[dst]=0 and in_valid=1:
  - in_ready=0, no state change, the beat stays upstream.
  - No head-of-line bypass: the block never reorders or skips the input beat.
- Input protocol: upstream holds in_data and in_sel stable while in_valid & !in_ready. The bench asserts this.
- Output protocol: out_data[k] is stable while out_valid[k] & !out_ready[k]. The bench asserts this.
- in_valid=0: no load; drains still occur.
- Round-robin mode:
  - rr_ptr increments by 1 mod 4 on each accepted beat only, wrapping 3→0.
  - A stall on the current channel stalls the whole input. The pointer never advances past a full channel.

Optional Feature:
- Macro: DEMUX_RR_EN.
- Defined:
  - Destination is the internal 2-bit rr_ptr; in_sel is ignored.
  - rr_ptr is a register, reset to 0, advancing per accepted beat as above.
- Undefined:
  - Destination is in_sel.
  - No pointer register is synthesized; rr_ptr is tied to 0.
  - All other behaviour is identical.

Test Plan:
1. Reset mid-operation: load channels 1 and 2, then pulse rst_n low between clock edges. Required: out_valid=0000, all out_data=0 and rr_ptr=0 immediately, before the next edge.
2. Explicit routing (no macro), out_ready=1111: send 8'hA0..8'hA3 with in_sel=0,1,2,3 on consecutive cycles. Required: each out_valid[k] pulses one cycle after acceptance with out_data[k]=8'hA0+k, and in_ready stays 1 throughout.
3. Backpressure isolation: out_ready[2]=0 with channel 2 holding 8'h55. A beat with in_sel=2 sees in_ready=0, and out_data[2] stays 8'h55. A beat with in_sel=0 is accepted the same cycle the stalled beat is withdrawn. Releasing out_ready[2] for one cycle lets the stalled beat load on that edge.
4. Back-to-back same channel: out_ready[3]=1, in_sel=3, 4 consecutive beats 1,2,3,4. Required: out_valid[3] is continuously 1 for 4 cycles, data 1,2,3,4 with no bubble.
5. Round-robin (DEMUX_RR_EN), out_ready=1111: send 6 beats. Required: destinations 0,1,2,3,0,1, and rr_ptr reads 2 afterwards.
6. Round-robin stall (DEMUX_RR_EN): out_ready[1]=0 with channel 1 full and rr_ptr=1. Required: in_ready=0 and rr_ptr holds at 1 for 5 cycles. On release, the beat goes to channel 1 and rr_ptr becomes 2.

Source files
------------

// File: rtl/stream_demux1_4.sv
// stream_demux1_4: registered 1-to-4 stream demultiplexer.
// Each input beat goes to one of four channel holding registers. Every
// channel has its own valid/ready handshake, so a stalled channel only
// blocks beats addressed to it.
// Build option: define DEMUX_RR_EN to take the destination from an internal
// round-robin pointer instead of in_sel.
module stream_demux1_4 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      in_sel,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*DW-1:0] out_data,
    output logic [1:0]      rr_ptr
);

    logic [3:0]    valid_r;
    logic [DW-1:0] data_r [4];
    logic [1:0]    dst_s;
    logic          ready_s;
    logic          accept_s;
    logic [3:0]    load_s;

`ifdef DEMUX_RR_EN
    logic [1:0] ptr_r;
    logic       sel_unused_s;

    // in_sel has no role when the pointer picks the destination
    assign sel_unused_s = ^in_sel;

    // Round-robin pointer steps to the next channel only on an accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 2'd0;
        end else if (accept_s) begin
            ptr_r <= ptr_r + 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign dst_s  = ptr_r;
    assign rr_ptr = ptr_r;
`else
    assign dst_s  = in_sel;
    assign rr_ptr = 2'd0;
`endif

    // Ready looks only at the addressed channel: free, or being drained now
    always_comb begin
        ready_s = 1'b0;
        if (!valid_r[dst_s] || out_ready[dst_s]) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign in_ready = ready_s;
    assign accept_s = in_valid & ready_s;

    // One-hot load strobe; at most one channel loads per edge
    always_comb begin
        load_s = 4'b0000;
        if (accept_s) begin
            load_s = 4'b0001 << dst_s;
        end else begin
            load_s = 4'b0000;
        end
    end

    // Channel holding registers: reload wins over drain so there is no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_r[k] <= {DW{1'b0}};
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= 1'b1;
                    data_r[k]  <= in_data;
                end else if (valid_r[k] && out_ready[k]) begin
                    valid_r[k] <= 1'b0;
                    data_r[k]  <= data_r[k];
                end else begin
                    valid_r[k] <= valid_r[k];
                    data_r[k]  <= data_r[k];
                end
            end
        end
    end

    assign out_valid = valid_r;

    // Pack the channel registers onto the flat output bus
    always_comb begin
        out_data = {(4*DW){1'b0}};
        for (int k = 0; k < 4; k++) begin
            out_data[k*DW +: DW] = data_r[k];
        end
    end

endmodule

// File: tb/tb_stream_demux1_4.sv
// Directed bench for stream_demux1_4 (explicit-select tests by default,
// round-robin tests when DEMUX_RR_EN is defined).
module tb_stream_demux1_4;

    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_sel;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*DW-1:0] out_data;
    logic [1:0]      rr_ptr;

    int n_vec = 0;
    int n_err = 0;

    stream_demux1_4 #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] chan(input int k);
        return out_data[k*DW +: DW];
    endfunction

    // Protocol monitors, sampled on the falling edge
    int         rst_cnt = 0;
    int         rst_seen = 0;
    logic       allow_change = 1'b0;
    logic [3:0] p_valid = 4'b0000;
    logic [3:0] p_ready = 4'b0000;
    logic [4*DW-1:0] p_data = '0;
    logic       p_in_stall = 1'b0;
    logic [DW-1:0] p_in_data = '0;
    logic [1:0] p_in_sel = 2'd0;

    always @(negedge rst_n) rst_cnt = rst_cnt + 1;

    always @(negedge clk) begin
        if (rst_n && rst_seen == rst_cnt) begin
            for (int k = 0; k < 4; k++) begin
                if (p_valid[k] && !p_ready[k]) begin
                    check_val($sformatf("out_hold_valid%0d", k), {31'd0, out_valid[k]}, 32'd1);
                    check_val($sformatf("out_hold_data%0d", k), {24'd0, out_data[k*DW +: DW]},
                              {24'd0, p_data[k*DW +: DW]});
                end
            end
            if (p_in_stall && !allow_change) begin
                check_val("in_hold_valid", {31'd0, in_valid}, 32'd1);
                check_val("in_hold_data", {24'd0, in_data}, {24'd0, p_in_data});
`ifndef DEMUX_RR_EN
                check_val("in_hold_sel", {30'd0, in_sel}, {30'd0, p_in_sel});
`endif
            end
        end
        rst_seen   = rst_cnt;
        p_valid    = out_valid;
        p_ready    = out_ready;
        p_data     = out_data;
        p_in_stall = in_valid & ~in_ready;
        p_in_data  = in_data;
        p_in_sel   = in_sel;
    end

    // Mid-cycle reset pulse: everything must clear before the next edge
    task automatic reset_pulse_check();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        check_val("rst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'b0000;
        #3;
        check_val("por_out_valid", {28'd0, out_valid}, 32'd0);
        check_val("por_out_data", out_data, 32'd0);
        check_val("por_rr_ptr", {30'd0, rr_ptr}, 32'd0);
        check_val("por_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

`ifndef DEMUX_RR_EN
        // Reset mid-operation: channels 1 and 2 loaded and held
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h3C;
        tick();
        in_sel = 2'd2; in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        check_val("t1_loaded_valid", {28'd0, out_valid}, 32'h6);
        check_val("t1_loaded_data", out_data, 32'h00C3_3C00);
        reset_pulse_check();
        tick();

        // Explicit routing, all consumers ready
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sel = 2'(k); in_data = 8'hA0 + 8'(k);
            #1;
            check_val($sformatf("t2_in_ready%0d", k), {31'd0, in_ready}, 32'd1);
            tick();
            check_val($sformatf("t2_valid%0d", k), {28'd0, out_valid}, 32'd1 << k);
            check_val($sformatf("t2_data%0d", k), {24'd0, chan(k)}, 32'hA0 + k);
        end
        in_valid = 1'b0;
        tick();
        check_val("t2_drained", {28'd0, out_valid}, 32'd0);

        // Back-to-back beats to channel 3 with no bubble
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = 2'd3; in_data = 8'(i + 1);
            #1;
            check_val($sformatf("t4_in_ready%0d", i), {31'd0, in_ready}, 32'd1);
            tick();
            check_val($sformatf("t4_valid%0d", i), {28'd0, out_valid}, 32'h8);
            check_val($sformatf("t4_data%0d", i), {24'd0, chan(3)}, i + 1);
        end
        in_valid = 1'b0;
        tick();
        check_val("t4_drained", {28'd0, out_valid}, 32'd0);
        check_val("t4_data_kept", {24'd0, chan(3)}, 32'h04);

        // Backpressure isolation on channel 2
        out_ready = 4'b1011;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h55;
        tick();
        check_val("t3_load55", {24'd0, chan(2)}, 32'h55);
        in_data = 8'h77;
        #1;
        check_val("t3_blocked", {31'd0, in_ready}, 32'd0);
        tick();
        check_val("t3_hold_valid", {31'd0, out_valid[2]}, 32'd1);
        check_val("t3_hold_data", {24'd0, chan(2)}, 32'h55);
        allow_change = 1'b1;
        in_sel = 2'd0; in_data = 8'h11;
        #1;
        check_val("t3_other_ready", {31'd0, in_ready}, 32'd1);
        tick();
        allow_change = 1'b0;
        check_val("t3_ch0_valid", {28'd0, out_valid}, 32'h5);
        check_val("t3_ch0_data", {24'd0, chan(0)}, 32'h11);
        check_val("t3_ch2_still", {24'd0, chan(2)}, 32'h55);
        in_sel = 2'd2; in_data = 8'h77;
        #1;
        check_val("t3_reblocked", {31'd0, in_ready}, 32'd0);
        tick();
        out_ready = 4'b1111;
        #1;
        check_val("t3_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        out_ready = 4'b1011; in_valid = 1'b0;
        check_val("t3_load77_valid", {28'd0, out_valid}, 32'h4);
        check_val("t3_load77_data", {24'd0, chan(2)}, 32'h77);
        out_ready = 4'b1111;
        tick();
        check_val("t3_drained", {28'd0, out_valid}, 32'd0);
`else
        // Round-robin distribution, all consumers ready
        out_ready = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hB0 + 8'(i);
            #1;
            check_val($sformatf("t5_ptr%0d", i), {30'd0, rr_ptr}, i % 4);
            check_val($sformatf("t5_in_ready%0d", i), {31'd0, in_ready}, 32'd1);
            tick();
            check_val($sformatf("t5_valid%0d", i), {28'd0, out_valid}, 32'd1 << (i % 4));
            check_val($sformatf("t5_data%0d", i), {24'd0, chan(i % 4)}, 32'hB0 + i);
        end
        in_valid = 1'b0;
        tick();
        check_val("t5_ptr_end", {30'd0, rr_ptr}, 32'd2);

        // Round-robin stall on channel 1: fill it, then wrap back to it
        out_ready = 4'b1101;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 8'hD0 + 8'(i);
            tick();
        end
        check_val("t6_ptr_at1", {30'd0, rr_ptr}, 32'd1);
        check_val("t6_ch1_full", {31'd0, out_valid[1]}, 32'd1);
        check_val("t6_ch1_data", {24'd0, chan(1)}, 32'hD3);
        in_data = 8'hEE;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_val($sformatf("t6_stall_ready%0d", c), {31'd0, in_ready}, 32'd0);
            check_val($sformatf("t6_stall_ptr%0d", c), {30'd0, rr_ptr}, 32'd1);
            tick();
        end
        check_val("t6_ch1_kept", {24'd0, chan(1)}, 32'hD3);
        out_ready = 4'b1111;
        #1;
        check_val("t6_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_val("t6_ch1_new_valid", {28'd0, out_valid}, 32'h2);
        check_val("t6_ch1_new_data", {24'd0, chan(1)}, 32'hEE);
        check_val("t6_ptr_after", {30'd0, rr_ptr}, 32'd2);

        // Reset mid-operation with the pointer away from zero
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        check_val("t1_rr_loaded", {28'd0, out_valid}, 32'h6);
        check_val("t1_rr_ptr", {30'd0, rr_ptr}, 32'd3);
        reset_pulse_check();
`endif
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
